// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage result mux, 32 x 32-bit architectural register
// file with write-through bypass to the decode read ports, and a
// retired-instruction counter.
module wb_regfile #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_w,
  input  logic             reg_write_w,
  input  logic [1:0]       result_src_w,
  input  logic [4:0]       rd_w,
  input  logic [31:0]      alu_result_w,
  input  logic [31:0]      read_data_w,
  input  logic [31:0]      pc_plus4_w,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  output logic [31:0]      rd1_d,
  output logic [31:0]      rd2_d,
  output logic [31:0]      result_w,
  output logic [CNT_W-1:0] instret
);

  logic [31:0]      regs_q [32];
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;
  logic             writeEn;

  // Select the writeback value; the reserved encoding yields zero so a
  // malformed select can never leak stale data into the forwarding path.
  always_comb begin
    result_w = '0;
    case (result_src_w)
      2'b00:   result_w = alu_result_w;
      2'b01:   result_w = read_data_w;
      2'b10:   result_w = pc_plus4_w;
      default: result_w = '0;
    endcase
  end

  // A write happens only for a real instruction with a legal source, never
  // to x0, and never while reset is held (this also disables the bypass).
  always_comb begin
    writeEn = valid_w && reg_write_w && (rd_w != 5'd0) &&
              (result_src_w != 2'b11) && !rst;
  end

  // Register array: asynchronous clear, otherwise commit the selected result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (writeEn) begin
      regs_q[rd_w] <= result_w;
    end
  end

  // Count every retiring instruction, wrapping naturally at the top.
  always_comb begin
    instret_d = instret_q;
    if (valid_w) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  // Retired-instruction counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

  // Read port 1: x0 and reset force zero, a same-cycle write is bypassed.
  always_comb begin
    rd1_d = regs_q[rs1_d];
    if (rst || (rs1_d == 5'd0)) begin
      rd1_d = '0;
    end else if (writeEn && (rd_w == rs1_d)) begin
      rd1_d = result_w;
    end
  end

  // Read port 2: identical rules to port 1 so aliased reads always agree.
  always_comb begin
    rd2_d = regs_q[rs2_d];
    if (rst || (rs2_d == 5'd0)) begin
      rd2_d = '0;
    end else if (writeEn && (rd_w == rs2_d)) begin
      rd2_d = result_w;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard-driven bench for wb_regfile. Expected values are
// pushed as stimulus is driven and popped when the outputs are sampled.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_w;
  logic        reg_write_w;
  logic [1:0]  result_src_w;
  logic [4:0]  rd_w;
  logic [31:0] alu_result_w;
  logic [31:0] read_data_w;
  logic [31:0] pc_plus4_w;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic [31:0] rd1_d;
  logic [31:0] rd2_d;
  logic [31:0] result_w;
  logic [63:0] instret;
  logic [31:0] rd1Small;
  logic [31:0] rd2Small;
  logic [31:0] resultSmall;
  logic [3:0]  instret4;

  logic [63:0] expQ [$];
  logic [63:0] expVal;
  logic [31:0] modelRegs [32];
  logic [63:0] modelCnt;
  int          vecCount  = 0;
  int          missCount = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .valid_w(valid_w), .reg_write_w(reg_write_w),
    .result_src_w(result_src_w), .rd_w(rd_w), .alu_result_w(alu_result_w),
    .read_data_w(read_data_w), .pc_plus4_w(pc_plus4_w), .rs1_d(rs1_d),
    .rs2_d(rs2_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .result_w(result_w),
    .instret(instret)
  );

  wb_regfile #(.CNT_W(4)) dutSmall (
    .clk(clk), .rst(rst), .valid_w(valid_w), .reg_write_w(reg_write_w),
    .result_src_w(result_src_w), .rd_w(rd_w), .alu_result_w(alu_result_w),
    .read_data_w(read_data_w), .pc_plus4_w(pc_plus4_w), .rs1_d(rs1_d),
    .rs2_d(rs2_d), .rd1_d(rd1Small), .rd2_d(rd2Small), .result_w(resultSmall),
    .instret(instret4)
  );

  function automatic logic [31:0] expResult();
    case (result_src_w)
      2'b00:   return alu_result_w;
      2'b01:   return read_data_w;
      2'b10:   return pc_plus4_w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic expWrite();
    return valid_w && reg_write_w && (rd_w != 5'd0) && (result_src_w != 2'b11) && !rst;
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] idx);
    if (rst || idx == 5'd0) return 32'h0;
    if (expWrite() && rd_w == idx) return expResult();
    return modelRegs[idx];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) modelRegs[i] = 32'h0;
    modelCnt = 64'h0;
  endtask

  task automatic setIdle();
    valid_w = 1'b0; reg_write_w = 1'b0; result_src_w = 2'b00; rd_w = 5'd0;
    alu_result_w = 32'h0; read_data_w = 32'h0; pc_plus4_w = 32'h0;
    rs1_d = 5'd0; rs2_d = 5'd0;
  endtask

  // Advance one clock: update the model with what the DUT sees at the edge,
  // then return at the following falling edge ready for new stimulus.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      clearModel();
    end else begin
      if (expWrite()) modelRegs[rd_w] = expResult();
      if (valid_w) modelCnt = modelCnt + 64'd1;
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    setIdle();
    rst = 1'b1;
    clearModel();
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setIdle();
    clearModel();
    @(negedge clk);
    valid_w = 1'b1; reg_write_w = 1'b1; rd_w = 5'd5; alu_result_w = 32'hCAFE0001;
    rs1_d = 5'd5; rs2_d = 5'd5;
    #1;
    expQ.push_back(64'h0);
    expVal = expQ.pop_front(); vecCount++;
    if (64'(rd1_d) !== expVal) begin missCount++; $display("[TB] FAIL reset_rd1_bypass_off: got %h expected %h", rd1_d, expVal); end
    expQ.push_back(64'h0);
    expVal = expQ.pop_front(); vecCount++;
    if (instret !== expVal) begin missCount++; $display("[TB] FAIL reset_instret: got %h expected %h", instret, expVal); end
    tick();
    setIdle();
    rst = 1'b0;
    rs1_d = 5'd5;
    #1;
    expQ.push_back(64'h0);
    expVal = expQ.pop_front(); vecCount++;
    if (64'(rd1_d) !== expVal) begin missCount++; $display("[TB] FAIL reset_write_suppressed: got %h expected %h", rd1_d, expVal); end
    expQ.push_back(64'h0);
    expVal = expQ.pop_front(); vecCount++;
    if (instret !== expVal) begin missCount++; $display("[TB] FAIL reset_count_suppressed: got %h expected %h", instret, expVal); end
  endtask

  task automatic test_result_mux();
    logic [31:0] muxExp [4];
    muxExp = '{32'h11, 32'h22, 32'h33, 32'h0};
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      setIdle();
      alu_result_w = 32'h11; read_data_w = 32'h22; pc_plus4_w = 32'h33;
      result_src_w = 2'(s);
      #1;
      expQ.push_back(64'(muxExp[s]));
      expVal = expQ.pop_front(); vecCount++;
      if (64'(result_w) !== expVal) begin missCount++; $display("[TB] FAIL result_mux_src%0d: got %h expected %h", s, result_w, expVal); end
    end
  endtask

  task automatic test_write_read();
    doReset();
    @(negedge clk);
    valid_w = 1'b1; reg_write_w = 1'b1; result_src_w = 2'b00; rd_w = 5'd5;
    alu_result_w = 32'hDEADBEEF; rs1_d = 5'd1; rs2_d = 5'd2;
    tick();
    setIdle();
    rs1_d = 5'd5;
    #1;
    expQ.push_back(64'h00000000DEADBEEF);
    expVal = expQ.pop_front(); vecCount++;
    if (64'(rd1_d) !== expVal) begin missCount++; $display("[TB] FAIL write_then_read: got %h expected %h", rd1_d, expVal); end
  endtask

  task automatic test_bypass();
    doReset();
    @(negedge clk);
    valid_w = 1'b1; reg_write_w = 1'b1; result_src_w = 2'b00; rd_w = 5'd7;
    alu_result_w = 32'h1234; rs1_d = 5'd7; rs2_d = 5'd7;
    #1;
    expQ.push_back(64'h1234);
    expQ.push_back(64'h1234);
    expVal = expQ.pop_front(); vecCount++;
    if (64'(rd1_d) !== expVal) begin missCount++; $display("[TB] FAIL bypass_rd1: got %h expected %h", rd1_d, expVal); end
    expVal = expQ.pop_front(); vecCount++;
    if (64'(rd2_d) !== expVal) begin missCount++; $display("[TB] FAIL bypass_rd2: got %h expected %h", rd2_d, expVal); end
    // Reserved select must neither write nor bypass.
    result_src_w = 2'b11; rd_w = 5'd8; rs1_d = 5'd8;
    #1;
    expQ.push_back(64'h0);
    expVal = expQ.pop_front(); vecCount++;
    if (64'(rd1_d) !== expVal) begin missCount++; $display("[TB] FAIL bypass_reserved_src: got %h expected %h", rd1_d, expVal); end
  endtask

  task automatic test_x0();
    doReset();
    @(negedge clk);
    valid_w = 1'b1; reg_write_w = 1'b1; result_src_w = 2'b00; rd_w = 5'd0;
    alu_result_w = 32'hFFFFFFFF; rs1_d = 5'd0; rs2_d = 5'd0;
    #1;
    expQ.push_back(64'h0);
    expVal = expQ.pop_front(); vecCount++;
    if (64'(rd1_d) !== expVal) begin missCount++; $display("[TB] FAIL x0_same_cycle: got %h expected %h", rd1_d, expVal); end
    tick();
    setIdle();
    tick();
    #1;
    expQ.push_back(64'h0);
    expQ.push_back(64'h0);
    expVal = expQ.pop_front(); vecCount++;
    if (64'(rd1_d) !== expVal) begin missCount++; $display("[TB] FAIL x0_later_rd1: got %h expected %h", rd1_d, expVal); end
    expVal = expQ.pop_front(); vecCount++;
    if (64'(rd2_d) !== expVal) begin missCount++; $display("[TB] FAIL x0_later_rd2: got %h expected %h", rd2_d, expVal); end
  endtask

  task automatic test_counter();
    doReset();
    for (int i = 0; i < 10; i++) begin
      setIdle();
      valid_w = 1'b1;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      setIdle();
      reg_write_w = 1'b1; rd_w = 5'd9; alu_result_w = 32'h99;
      tick();
    end
    setIdle();
    rs1_d = 5'd9;
    #1;
    expQ.push_back(64'd10);
    expVal = expQ.pop_front(); vecCount++;
    if (instret !== expVal) begin missCount++; $display("[TB] FAIL counter_10_valid: got %0d expected %0d", instret, expVal); end
    expQ.push_back(64'h0);
    expVal = expQ.pop_front(); vecCount++;
    if (64'(rd1_d) !== expVal) begin missCount++; $display("[TB] FAIL invalid_no_write: got %h expected %h", rd1_d, expVal); end
  endtask

  task automatic test_wrap();
    doReset();
    for (int i = 0; i < 15; i++) begin
      setIdle();
      valid_w = 1'b1;
      tick();
    end
    #1;
    expQ.push_back(64'd15);
    expVal = expQ.pop_front(); vecCount++;
    if (64'(instret4) !== expVal) begin missCount++; $display("[TB] FAIL wrap_pre: got %0d expected %0d", instret4, expVal); end
    valid_w = 1'b1;
    tick();
    setIdle();
    #1;
    expQ.push_back(64'd0);
    expVal = expQ.pop_front(); vecCount++;
    if (64'(instret4) !== expVal) begin missCount++; $display("[TB] FAIL wrap_to_zero: got %0d expected %0d", instret4, expVal); end
    expQ.push_back(64'd16);
    expVal = expQ.pop_front(); vecCount++;
    if (instret !== expVal) begin missCount++; $display("[TB] FAIL wide_no_wrap: got %0d expected %0d", instret, expVal); end
  endtask

  task automatic test_reset_mid_run();
    doReset();
    @(negedge clk);
    valid_w = 1'b1; reg_write_w = 1'b1; rd_w = 5'd3; alu_result_w = 32'hA5A5A5A5;
    tick();
    for (int i = 0; i < 8; i++) begin
      setIdle();
      valid_w = 1'b1;
      tick();
    end
    setIdle();
    rs1_d = 5'd3; rs2_d = 5'd3;
    #1;
    expQ.push_back(64'h00000000A5A5A5A5);
    expVal = expQ.pop_front(); vecCount++;
    if (64'(rd1_d) !== expVal) begin missCount++; $display("[TB] FAIL midrun_x3_before: got %h expected %h", rd1_d, expVal); end
    expQ.push_back(64'd9);
    expVal = expQ.pop_front(); vecCount++;
    if (instret !== expVal) begin missCount++; $display("[TB] FAIL midrun_instret_before: got %0d expected %0d", instret, expVal); end
    // A write is presented, then reset lands in the same cycle.
    valid_w = 1'b1; reg_write_w = 1'b1; rd_w = 5'd3; alu_result_w = 32'h77;
    #1;
    rst = 1'b1;
    clearModel();
    #1;
    expQ.push_back(64'h0);
    expVal = expQ.pop_front(); vecCount++;
    if (64'(rd1_d) !== expVal) begin missCount++; $display("[TB] FAIL midrun_x3_at_reset: got %h expected %h", rd1_d, expVal); end
    expQ.push_back(64'h0);
    expVal = expQ.pop_front(); vecCount++;
    if (instret !== expVal) begin missCount++; $display("[TB] FAIL midrun_instret_at_reset: got %0d expected %0d", instret, expVal); end
    #1;
    rst = 1'b0;
    valid_w = 1'b0;
    tick();
    #1;
    expQ.push_back(64'h0);
    expVal = expQ.pop_front(); vecCount++;
    if (64'(rd2_d) !== expVal) begin missCount++; $display("[TB] FAIL midrun_write_lost: got %h expected %h", rd2_d, expVal); end
    valid_w = 1'b1; reg_write_w = 1'b1; rd_w = 5'd3; alu_result_w = 32'h5A5A0003;
    rs1_d = 5'd1;
    tick();
    setIdle();
    rs1_d = 5'd3;
    #1;
    expQ.push_back(64'h000000005A5A0003);
    expVal = expQ.pop_front(); vecCount++;
    if (64'(rd1_d) !== expVal) begin missCount++; $display("[TB] FAIL post_reset_write: got %h expected %h", rd1_d, expVal); end
    expQ.push_back(64'd1);
    expVal = expQ.pop_front(); vecCount++;
    if (instret !== expVal) begin missCount++; $display("[TB] FAIL post_reset_count: got %0d expected %0d", instret, expVal); end
  endtask

  task automatic test_back_to_back();
    doReset();
    for (int n = 0; n < 60; n++) begin
      valid_w      = ($urandom_range(0, 3) != 0);
      reg_write_w  = ($urandom_range(0, 3) != 0);
      result_src_w = 2'($urandom_range(0, 3));
      rd_w         = 5'($urandom_range(0, 31));
      alu_result_w = $urandom;
      read_data_w  = $urandom;
      pc_plus4_w   = $urandom;
      rs1_d        = ($urandom_range(0, 2) == 0) ? rd_w : 5'($urandom_range(0, 31));
      rs2_d        = ($urandom_range(0, 2) == 0) ? rd_w : 5'($urandom_range(0, 31));
      #1;
      expQ.push_back(64'(expRead(rs1_d)));
      expQ.push_back(64'(expRead(rs2_d)));
      expQ.push_back(64'(expResult()));
      expQ.push_back(modelCnt);
      expVal = expQ.pop_front(); vecCount++;
      if (64'(rd1_d) !== expVal) begin missCount++; $display("[TB] FAIL b2b_rd1 step %0d: got %h expected %h", n, rd1_d, expVal); end
      expVal = expQ.pop_front(); vecCount++;
      if (64'(rd2_d) !== expVal) begin missCount++; $display("[TB] FAIL b2b_rd2 step %0d: got %h expected %h", n, rd2_d, expVal); end
      expVal = expQ.pop_front(); vecCount++;
      if (64'(result_w) !== expVal) begin missCount++; $display("[TB] FAIL b2b_result step %0d: got %h expected %h", n, result_w, expVal); end
      expVal = expQ.pop_front(); vecCount++;
      if (instret !== expVal) begin missCount++; $display("[TB] FAIL b2b_instret step %0d: got %0d expected %0d", n, instret, expVal); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_result_mux();
    test_write_read();
    test_bypass();
    test_x0();
    test_counter();
    test_wrap();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
